// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory responder.
package mem_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CMD_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        REQ_CMD  = 1'b0,
        REQ_DATA = 1'b1
    } req_kind_t;

endpackage

// File: rtl/mem_regfile.sv
// Data register file: asynchronous clear, one synchronous write port, one combinational read port.
module mem_regfile #(
    parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_adr,
    output logic [DATA_W-1:0] rd_data_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every entry on reset; otherwise accept one write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_adr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves command fetches from the instruction store and
// operand reads from the data register file, one dv pulse per served request.
module mem_responder #(
    parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W     = mem_pkg::DATA_W,
    parameter int unsigned CMD_W      = mem_pkg::CMD_W,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              give_c,
    input  logic              give_d,
    input  logic              write_data,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_adr,
    input  logic [CMD_W-1:0]  load_cmd,
    output logic              dv,
    output logic [CMD_W-1:0]  com,
    output logic [DATA_W-1:0] data_t,
    output logic              busy,
    output logic              err
);

    import mem_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

    state_t            state, state_n;
    req_kind_t         kind_q, kind_n;
    logic [ADDR_W-1:0] adr_q, adr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              dv_n;
    logic [CMD_W-1:0]  com_n;
    logic [DATA_W-1:0] data_n;
    logic              busy_n;
    logic              err_n;
    logic              wr_en_c;
    logic [DATA_W-1:0] rd_data_c;

    logic [CMD_W-1:0]  imem [DEPTH];

    mem_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en_c),
        .wr_adr    (adr),
        .wr_data   (wdata),
        .rd_adr    (adr_q),
        .rd_data_c (rd_data_c)
    );

    // Instruction store load port; deliberately not reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            imem[load_adr] <= load_cmd;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            kind_q <= REQ_CMD;
            adr_q  <= '0;
            cnt    <= '0;
            dv     <= 1'b0;
            com    <= '0;
            data_t <= '0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            kind_q <= kind_n;
            adr_q  <= adr_n;
            cnt    <= cnt_n;
            dv     <= dv_n;
            com    <= com_n;
            data_t <= data_n;
            busy   <= busy_n;
            err    <= err_n;
        end
    end

    // Next-state, request acceptance and response capture.
    always_comb begin
        state_n = state;
        kind_n  = kind_q;
        adr_n   = adr_q;
        cnt_n   = cnt;
        dv_n    = 1'b0;
        com_n   = com;
        data_n  = data_t;
        err_n   = err;
        wr_en_c = 1'b0;

        unique case (state)
            IDLE: begin
                if (write_data) begin
                    wr_en_c = 1'b1;
                end else if (give_c || give_d) begin
                    adr_n   = adr;
                    kind_n  = give_c ? REQ_CMD : REQ_DATA;
                    cnt_n   = CNT_W'(RD_LATENCY);
                    state_n = FETCH;
                    if (give_c && give_d) begin
                        err_n = 1'b1;
                    end
                end
            end
            FETCH: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = RESP;
                    dv_n    = 1'b1;
                    if (kind_q == REQ_CMD) begin
                        com_n = imem[adr_q];
                    end else begin
                        data_n = rd_data_c;
                    end
                end
            end
            RESP: begin
                state_n = RELEASE;
            end
            RELEASE: begin
                // Wait for the requester to drop its level so a held request is not re-served.
                if (!give_c && !give_d) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Writes are only legal while idle; anywhere else they are dropped and flagged.
        if (write_data && (state != IDLE)) begin
            err_n = 1'b1;
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a transaction-level model.
module tb_mem_responder;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CMD_W  = 16;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              give_c;
    logic              give_d;
    logic              write_data;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic              load_en;
    logic [ADDR_W-1:0] load_adr;
    logic [CMD_W-1:0]  load_cmd;
    logic              dv;
    logic [CMD_W-1:0]  com;
    logic [DATA_W-1:0] data_t;
    logic              busy;
    logic              err;

    // Reference model state
    logic [CMD_W-1:0]  imem_m [DEPTH];
    logic [DATA_W-1:0] dmem_m [DEPTH];
    logic [CMD_W-1:0]  com_m;
    logic [DATA_W-1:0] data_m;
    logic              err_m;

    int n_vec = 0;
    int n_err = 0;

    mem_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CMD_W      (CMD_W),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .give_c     (give_c),
        .give_d     (give_d),
        .write_data (write_data),
        .adr        (adr),
        .wdata      (wdata),
        .load_en    (load_en),
        .load_adr   (load_adr),
        .load_cmd   (load_cmd),
        .dv         (dv),
        .com        (com),
        .data_t     (data_t),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_dv"},     32'(dv),     32'(0));
        check_eq({tag, "_busy"},   32'(busy),   32'(0));
        check_eq({tag, "_com"},    32'(com),    32'(com_m));
        check_eq({tag, "_data_t"}, 32'(data_t), 32'(data_m));
        check_eq({tag, "_err"},    32'(err),    32'(err_m));
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) dmem_m[i] = '0;
        com_m  = '0;
        data_m = '0;
        err_m  = 1'b0;
    endtask

    task automatic load_imem(input logic [ADDR_W-1:0] a, input logic [CMD_W-1:0] w);
        load_en  = 1'b1;
        load_adr = a;
        load_cmd = w;
        @(negedge clk);
        load_en  = 1'b0;
        imem_m[a] = w;
    endtask

    task automatic write_idle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        write_data = 1'b1;
        adr        = a;
        wdata      = w;
        @(negedge clk);
        write_data = 1'b0;
        dmem_m[a]  = w;
        check_eq("write_no_dv", 32'(dv), 32'(0));
        check_eq("write_no_busy", 32'(busy), 32'(0));
    endtask

    // One request: waits for dv, optionally pokes a write/load while fetching,
    // holds the request `hold` cycles past dv, then releases and waits for idle.
    task automatic request(input bit c, input bit d, input logic [ADDR_W-1:0] a, input int hold,
                           input bit wr_busy, input logic [ADDR_W-1:0] wr_adr,
                           input bit ld_busy, input logic [CMD_W-1:0] ld_word);
        int  n;
        int  m;
        int  extra_dv;
        bit  got;
        give_c = c;
        give_d = d;
        adr    = a;
        if (c) com_m = imem_m[a];
        else   data_m = dmem_m[a];
        if (c && d) err_m = 1'b1;
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            write_data = 1'b0;
            load_en    = 1'b0;
            if (dv) begin
                got = 1'b1;
            end else if (n == 1) begin
                adr = wr_busy ? wr_adr : ~a;
                if (wr_busy) begin
                    write_data = 1'b1;
                    wdata      = DATA_W'($urandom);
                    err_m      = 1'b1;
                end
                if (ld_busy) begin
                    load_en  = 1'b1;
                    load_adr = a;
                    load_cmd = ld_word;
                    imem_m[a] = ld_word;
                end
            end
        end
        check_eq("dv_latency", 32'(n), 32'(RD_LAT + 1));
        check_eq("resp_com", 32'(com), 32'(com_m));
        check_eq("resp_data_t", 32'(data_t), 32'(data_m));
        check_eq("resp_err", 32'(err), 32'(err_m));
        extra_dv = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (dv) extra_dv++;
        end
        give_c = 1'b0;
        give_d = 1'b0;
        m = 0;
        do begin
            @(negedge clk);
            m++;
            if (dv) extra_dv++;
        end while (busy && m < 20);
        check_eq("extra_dv", 32'(extra_dv), 32'(0));
        check_eq("idle_delay", 32'(m), 32'((hold == 0) ? 2 : 1));
        check_eq("idle_err", 32'(err), 32'(err_m));
    endtask

    // Reset in the middle of a fetch: transaction abandoned, storage state per reset rules.
    task automatic reset_mid_fetch(input logic [ADDR_W-1:0] a);
        int extra_dv;
        give_d = 1'b1;
        adr    = a;
        @(negedge clk);
        check_eq("rst_pre_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_dv", 32'(dv), 32'(0));
        give_d = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        extra_dv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dv) extra_dv++;
        end
        check_eq("rst_no_dv", 32'(extra_dv), 32'(0));
        check_idle_outputs("post_rst");
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        int                op;
        int                k;

        rst_n      = 1'b0;
        give_c     = 1'b0;
        give_d     = 1'b0;
        write_data = 1'b0;
        adr        = '0;
        wdata      = '0;
        load_en    = 1'b0;
        load_adr   = '0;
        load_cmd   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed walk through the basic scenarios
        load_imem(4'h0, 16'h1A2B);
        request(1, 0, 4'h0, 0, 0, '0, 0, '0);
        for (int i = 1; i < int'(DEPTH); i++) load_imem(ADDR_W'(i), CMD_W'($urandom));
        write_idle(4'h5, 4'h9);
        request(0, 1, 4'h5, 0, 0, '0, 0, '0);
        request(0, 1, 4'h5, 6, 0, '0, 0, '0);
        request(1, 1, 4'h3, 0, 0, '0, 0, '0);
        request(0, 1, 4'h7, 2, 1, 4'h2, 0, '0);
        request(0, 1, 4'h2, 0, 0, '0, 0, '0);
        request(1, 0, 4'h9, 1, 0, '0, 1, 16'hBEEF);
        request(1, 0, 4'h9, 0, 0, '0, 0, '0);
        reset_mid_fetch(4'h5);
        request(0, 1, 4'h5, 0, 0, '0, 0, '0);
        request(1, 0, 4'h3, 0, 0, '0, 0, '0);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            op = int'($urandom_range(0, 19));
            a  = ADDR_W'($urandom);
            if (op < 3) begin
                load_imem(a, CMD_W'($urandom));
            end else if (op < 8) begin
                write_idle(a, DATA_W'($urandom));
            end else if (op < 19) begin
                k = int'($urandom_range(0, 9));
                request(k < 5, k >= 4, a, int'($urandom_range(0, 4)),
                        ($urandom_range(0, 7) == 0), ADDR_W'($urandom),
                        ($urandom_range(0, 7) == 0), CMD_W'($urandom));
            end else begin
                reset_mid_fetch(a);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
